// File: rtl/imager_stream_if.sv
// imager_stream_if: downstream valid/ready pixel stream.
// Each word is one pixel with start-of-frame and end-of-line markers.
interface imager_stream_if #(
   parameter int DATA_WIDTH = 10
);
   logic [DATA_WIDTH-1:0] out_dat;
   logic                  out_sof;
   logic                  out_eol;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output out_dat, out_sof, out_eol, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_dat, out_sof, out_eol, out_valid,
      output out_ready
   );
endinterface

// File: rtl/imager_stream.sv
// imager_stream: converts the imager fv/lv/dat raster into a FIFO-buffered
// valid/ready stream tagged with sof/eol. A frame that cannot fit is dropped
// from the overflow point on, and the loss is flagged and counted.
// Optional feature macro: IMAGER_STREAM_STATS_EN builds the line/row counters;
// without it line_len and frame_rows read as zero.
module imager_stream #(
   parameter int DATA_WIDTH     = 10,
   parameter int FIFO_AW        = 9,
   parameter int NUM_ROWS_WIDTH = 12,
   parameter int NUM_COLS_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [DATA_WIDTH-1:0]     dat,
   input  logic                      fv,
   input  logic                      lv,
   imager_stream_if.master           strm,
   output logic [FIFO_AW:0]          fifo_level,
   output logic                      overflow,
   output logic [15:0]               dropped_frames,
   output logic [NUM_COLS_WIDTH:0]   line_len,
   output logic [NUM_ROWS_WIDTH:0]   frame_rows
);

   localparam int WW    = DATA_WIDTH + 2;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_LVL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   LVL_ONE  = 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DROP} state_t;

   state_t                  state_q;
   logic                    hold_v_q;
   logic [DATA_WIDTH-1:0]   hold_dat_q;
   logic                    sof_pend_q;
   logic                    overflow_q;
   logic [15:0]             dropped_q;

   logic [WW-1:0]           mem [DEPTH];
   logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]        level_q, mem_cnt;
   logic                    out_valid_q, out_sof_q, out_eol_q;
   logic [DATA_WIDTH-1:0]   out_dat_q;

   logic                    capture, push_req, push_eol, ovf, push, pop, load;
   logic [WW-1:0]           push_word;

   // Decide this cycle's capture and whether the held pixel must be pushed.
   // Fullness uses the pre-pop level (out register counts as an entry).
   always_comb begin
      capture  = enable && fv && lv && (state_q == S_ACTIVE || state_q == S_ARMED);
      push_req = 1'b0;
      push_eol = 1'b0;
      if (enable && state_q == S_ACTIVE && hold_v_q) begin
         push_req = 1'b1;
         push_eol = !(fv && lv);
      end
      ovf       = push_req && (level_q == FULL_LVL);
      push      = push_req && !ovf;
      push_word = {sof_pend_q, push_eol, hold_dat_q};
   end

   assign mem_cnt = level_q - {{FIFO_AW{1'b0}}, out_valid_q};
   assign pop     = out_valid_q && strm.out_ready;
   assign load    = (mem_cnt != '0) && (!out_valid_q || pop);

   // Capture FSM: arming, hold register, sof tagging and frame dropping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         hold_v_q   <= 1'b0;
         hold_dat_q <= '0;
         sof_pend_q <= 1'b0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else if (!enable) begin
         state_q  <= S_IDLE;
         hold_v_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (!fv) state_q <= S_ARMED;
            S_ARMED: begin
               if (fv) begin
                  state_q    <= S_ACTIVE;
                  sof_pend_q <= 1'b1;
                  if (capture) begin
                     hold_v_q   <= 1'b1;
                     hold_dat_q <= dat;
                  end
               end
            end
            S_ACTIVE: begin
               if (ovf) begin
                  hold_v_q   <= 1'b0;
                  overflow_q <= 1'b1;
                  if (dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
                  state_q    <= S_DROP;
               end else begin
                  if (push) sof_pend_q <= 1'b0;
                  hold_v_q <= capture;
                  if (capture) hold_dat_q <= dat;
                  if (!fv) state_q <= S_ARMED;
               end
            end
            default: if (!fv) state_q <= S_ARMED;
         endcase
      end
   end

   // Storage array: write port only, no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_word;
   end

   // FIFO pointers, occupancy and the registered output word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_dat_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (load) begin
            {out_sof_q, out_eol_q, out_dat_q} <= mem[rd_ptr_q];
            rd_ptr_q    <= rd_ptr_q + PTR_ONE;
            out_valid_q <= 1'b1;
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   assign strm.out_dat    = out_dat_q;
   assign strm.out_sof    = out_sof_q;
   assign strm.out_eol    = out_eol_q;
   assign strm.out_valid  = out_valid_q;
   assign fifo_level      = level_q;
   assign overflow        = overflow_q;
   assign dropped_frames  = dropped_q;

`ifdef IMAGER_STREAM_STATS_EN
   localparam logic [NUM_COLS_WIDTH:0] COL_ONE = 1;
   logic [NUM_COLS_WIDTH:0] col_q, line_len_q;
   logic [NUM_ROWS_WIDTH:0] row_q, frame_rows_q, rows_d;
   logic                    eol_push;

   assign eol_push = push && push_eol;
   assign rows_d   = row_q + (NUM_ROWS_WIDTH+1)'(eol_push);

   // Line/row counters; frozen while a frame is being dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q        <= '0;
         row_q        <= '0;
         line_len_q   <= '0;
         frame_rows_q <= '0;
      end else if (!enable) begin
         col_q <= '0;
         row_q <= '0;
      end else if (state_q == S_ARMED && fv) begin
         col_q <= capture ? COL_ONE : '0;
         row_q <= '0;
      end else if (state_q == S_ACTIVE && !ovf) begin
         if (eol_push) begin
            line_len_q <= col_q;
            col_q      <= '0;
         end else if (capture) begin
            col_q <= col_q + COL_ONE;
         end
         if (!fv) begin
            frame_rows_q <= rows_d;
            row_q        <= '0;
         end else begin
            row_q <= rows_d;
         end
      end
   end

   assign line_len   = line_len_q;
   assign frame_rows = frame_rows_q;
`else
   assign line_len   = '0;
   assign frame_rows = '0;
`endif

endmodule

// File: tb/tb_imager_stream.sv
// tb_imager_stream: randomized raster stimulus against a queue-based
// reference model of the stream; one line per delivered word.
module tb_imager_stream;
   localparam int DW = 10, AW = 3, DEPTH = 8, RW = 12, CW = 12;
`ifdef IMAGER_STREAM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int M_IDLE = 0, M_ARMED = 1, M_ACTIVE = 2, M_DROP = 3;
   localparam int RM_ONE = 0, RM_TOG = 1, RM_ZERO = 2, RM_RAND = 3;

   logic          clk = 1'b0;
   logic          reset_n, enable, fv, lv;
   logic [DW-1:0] dat;
   logic [AW:0]   fifo_level;
   logic          overflow;
   logic [15:0]   dropped_frames;
   logic [CW:0]   line_len;
   logic [RW:0]   frame_rows;

   imager_stream_if #(.DATA_WIDTH(DW)) sif ();

   imager_stream #(
      .DATA_WIDTH(DW), .FIFO_AW(AW), .NUM_ROWS_WIDTH(RW), .NUM_COLS_WIDTH(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .dat(dat), .fv(fv), .lv(lv),
      .strm(sif.master), .fifo_level(fifo_level), .overflow(overflow),
      .dropped_frames(dropped_frames), .line_len(line_len), .frame_rows(frame_rows)
   );

   always #5 clk = ~clk;

   int n_total = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a word queue where each entry remembers the edge it
   // was written; it becomes visible at the output one edge later.
   typedef struct { logic [DW+1:0] w; int pe; } ent_t;
   ent_t          q[$];
   int            ecnt = 0, delivered = 0;
   int            m_st, m_col, m_rows, m_ll, m_fr, m_drop;
   bit            m_hv, m_sof, m_ovf;
   logic [DW-1:0] m_hd;
   bit            tog = 1'b0;

   function automatic void m_reset();
      q.delete();
      m_st = M_IDLE; m_hv = 0; m_hd = '0; m_sof = 0; m_ovf = 0;
      m_col = 0; m_rows = 0; m_ll = 0; m_fr = 0; m_drop = 0;
   endfunction

   function automatic void model_edge();
      bit vis, req, eol;
      int lvl;
      vis = q.size() > 0 && q[0].pe < ecnt;
      ecnt++;
      if (!reset_n) begin
         m_reset();
         return;
      end
      lvl = q.size();
      if (vis && sif.out_ready) begin
         $display("xfer %0d dat=%h sof=%0b eol=%0b", delivered,
                  q[0].w[DW-1:0], q[0].w[DW+1], q[0].w[DW]);
         delivered++;
         void'(q.pop_front());
      end
      req = 0; eol = 0;
      if (!enable) begin
         m_st = M_IDLE; m_hv = 0;
      end else begin
         case (m_st)
            M_IDLE:  if (!fv) m_st = M_ARMED;
            M_ARMED: if (fv) begin
               m_st = M_ACTIVE; m_sof = 1; m_rows = 0; m_col = 0;
               if (lv) begin m_hv = 1; m_hd = dat; m_col = 1; end
            end
            M_ACTIVE: begin
               if (m_hv) begin req = 1; eol = !(fv && lv); end
               if (req && lvl == DEPTH) begin
                  m_hv = 0; m_ovf = 1; m_st = M_DROP;
                  if (m_drop < 65535) m_drop++;
               end else begin
                  if (req) begin
                     q.push_back('{w: {m_sof, eol, m_hd}, pe: ecnt});
                     m_sof = 0;
                     if (eol) begin m_ll = m_col; m_col = 0; m_rows++; end
                  end
                  if (fv && lv) begin m_hv = 1; m_hd = dat; m_col++; end
                  else m_hv = 0;
                  if (!fv) begin m_fr = m_rows; m_rows = 0; m_st = M_ARMED; end
               end
            end
            default: if (!fv) m_st = M_ARMED;
         endcase
      end
   endfunction

   task automatic check_outputs();
      bit vis;
      vis = q.size() > 0 && q[0].pe < ecnt;
      chk("valid", sif.out_valid, vis);
      if (vis) chk("word", {sif.out_sof, sif.out_eol, sif.out_dat}, q[0].w);
      chk("level", fifo_level, q.size());
      chk("overflow", overflow, m_ovf);
      chk("dropped", dropped_frames, m_drop);
      chk("line_len", line_len, STATS ? m_ll : 0);
      chk("frame_rows", frame_rows, STATS ? m_fr : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic drv(input bit f, input bit l, input int rmode);
      fv = f; lv = l; dat = DW'($urandom);
      tog = ~tog;
      case (rmode)
         RM_ONE:  sif.out_ready = 1'b1;
         RM_TOG:  sif.out_ready = tog;
         RM_ZERO: sif.out_ready = 1'b0;
         default: sif.out_ready = 1'($urandom);
      endcase
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1 m_reset();
      chk("rst_valid", sif.out_valid, 0);
      chk("rst_dat", sif.out_dat, 0);
      chk("rst_sofeol", {sif.out_sof, sif.out_eol}, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", dropped_frames, 0);
      chk("rst_stats", {line_len, frame_rows}, 0);
      tick(); tick();
      reset_n = 1'b1;
   endtask

   task automatic run_frame(input int cols, input int rows, input int hb,
                            input int rmode, input int en_row, input int rst_row);
      repeat (3) begin drv(0, 0, rmode); tick(); end
      drv(1, 0, rmode); tick();
      for (int r = 0; r < rows; r++) begin
         if (r == en_row) enable = 1'b1;
         for (int c = 0; c < cols; c++) begin
            drv(1, 1, rmode);
            if (r == rst_row && c == cols / 2) async_reset();
            tick();
         end
         for (int h = 0; h < hb; h++) begin drv(1, 0, rmode); tick(); end
      end
      drv(0, 0, rmode); tick();
   endtask

   task automatic drain(input int n);
      repeat (n) begin drv(0, 0, RM_ONE); tick(); end
   endtask

   int d0;

   initial begin
      reset_n = 1'b0; enable = 1'b0; fv = 1'b0; lv = 1'b0; dat = '0;
      sif.out_ready = 1'b0;
      m_reset();
      tick(); tick();
      chk("reset_valid", sif.out_valid, 0);
      chk("reset_level", fifo_level, 0);
      reset_n = 1'b1; enable = 1'b1;
      drain(2);

      // 4x3 frame, always ready
      d0 = delivered;
      run_frame(4, 3, 2, RM_ONE, -1, -1); drain(12);
      chk("t1_words", delivered - d0, 12);
      chk("t1_line_len", line_len, STATS ? 4 : 0);
      chk("t1_frame_rows", frame_rows, STATS ? 3 : 0);

      // same frame, ready toggling
      d0 = delivered;
      run_frame(4, 3, 2, RM_TOG, -1, -1); drain(20);
      chk("t2_words", delivered - d0, 12);
      chk("t2_ovf", overflow, 0);

      // overflow: nothing consumed
      d0 = delivered;
      run_frame(4, 3, 2, RM_ZERO, -1, -1);
      chk("t3_level", fifo_level, DEPTH);
      chk("t3_ovf", overflow, 1);
      chk("t3_dropped", dropped_frames, 1);
      drain(12);
      chk("t3_drained", delivered - d0, DEPTH);
      d0 = delivered;
      run_frame(4, 3, 2, RM_ONE, -1, -1); drain(12);
      chk("t3_next_words", delivered - d0, 12);

      // enable raised mid-frame
      enable = 1'b0; drain(3);
      d0 = delivered;
      run_frame(4, 3, 2, RM_ONE, 1, -1); drain(12);
      chk("t4_words", delivered - d0, 0);
      run_frame(4, 3, 2, RM_ONE, -1, -1); drain(12);
      chk("t4_next_words", delivered - d0, 12);

      // one-column frame
      d0 = delivered;
      run_frame(1, 2, 2, RM_ONE, -1, -1); drain(12);
      chk("t5_words", delivered - d0, 2);
      chk("t5_line_len", line_len, STATS ? 1 : 0);
      chk("t5_frame_rows", frame_rows, STATS ? 2 : 0);

      // reset mid-line with queued words, then a clean frame
      run_frame(4, 3, 2, RM_ZERO, -1, 1); drain(12);
      d0 = delivered;
      run_frame(4, 3, 2, RM_ONE, -1, -1); drain(12);
      chk("t6_words", delivered - d0, 12);

      // randomized frames
      for (int i = 0; i < 40; i++) begin
         int cols, rows, hb, en_row;
         cols = $urandom_range(1, 8);
         rows = $urandom_range(1, 5);
         hb   = $urandom_range(0, 4);
         en_row = (i % 5 == 2) ? $urandom_range(0, rows - 1) : -1;
         enable = (en_row < 0);
         run_frame(cols, rows, hb, RM_RAND, en_row, -1);
      end
      enable = 1'b1;
      drain(30);
      chk("final_empty", fifo_level, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
